edge_seq_gen: RTL and testbench
===============================

EDGE_SEQ_GEN -- requirements
Module: edge_seq_gen

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the command FIFO depth (power of two, >=2).
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the width of the command hold length.
REQ-003 The block SHALL have parameter INIT, default 1'b0, setting the reset value of sig_out.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its posedge.
REQ-005 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have port cmd_valid  input  1  command offered.
REQ-007 The block SHALL have port cmd_ready  output  1  command can be accepted (FIFO not full).
REQ-008 The block SHALL have port cmd_op  input  2  operation: 00 HOLD, 01 RISE, 10 FALL, 11 TOGGLE.
REQ-009 The block SHALL have port cmd_len  input  CNT_W  extra cycles the value is held after the command's first cycle.
REQ-010 The block SHALL have port sig_out  output  1  generated waveform, registered.
REQ-011 The block SHALL have port ev_rose, ev_fell, ev_stable  output  1 each  sampled-value flags of sig_out against its value one clk earlier.
REQ-012 The block SHALL have port busy  output  1  FSM in RUN or FIFO non-empty.
REQ-013 The block SHALL have port done  output  1  high during the final cycle of each command window.
REQ-014 The block SHALL have port err  output  1  sticky illegal-edge flag.
REQ-015 The block SHALL have port err_clr  input  1  synchronous clear of err.

Function
REQ-016 A command SHALL be accepted on a posedge where cmd_valid && cmd_ready, and SHALL be pushed into the FIFO.
REQ-017 cmd_ready SHALL equal !full; it SHALL NOT depend combinationally on cmd_valid or on a same-cycle pop.
REQ-018 The FSM SHALL have two states: IDLE and RUN.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop the head at the next posedge, apply its op to sig_out at that edge, load remain=cmd_len, and enter RUN; acceptance-to-sig_out latency is 1 cycle.
REQ-020 Op effects on sig_out: HOLD unchanged; RISE sets 1; FALL sets 0; TOGGLE inverts.
REQ-021 In RUN with remain!=0, remain SHALL decrement each cycle and sig_out SHALL hold.
REQ-022 In RUN with remain==0, the FSM SHALL pop the next command back-to-back (no gap cycle) if the FIFO is non-empty, else return to IDLE.
REQ-023 Each command window SHALL last exactly 1+cmd_len cycles; cmd_len=0 is a 1-cycle window; cmd_len=2^CNT_W-1 SHALL NOT wrap.
REQ-024 done SHALL be high only in cycles with state==RUN && remain==0.
REQ-025 RISE while sig_out==1, or FALL while sig_out==0, SHALL leave sig_out unchanged, still consume its full window, and set err at the same edge.
REQ-026 When err_clr and a new error coincide, err SHALL end the cycle set (set wins).
REQ-027 ev_rose=sig_out&&!prev; ev_fell=!sig_out&&prev; ev_stable=(sig_out==prev); prev is sig_out registered one cycle.
REQ-028 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged; push when full is impossible by REQ-017.
REQ-029 In IDLE with the FIFO empty, sig_out SHALL hold its last value indefinitely.

Reset
REQ-030 On rst_n low, asynchronously: FIFO empty, state IDLE, remain=0, sig_out=INIT, prev=INIT, err=0.
REQ-031 During reset and in the first cycle after it, outputs SHALL be: cmd_ready=1, busy=0, done=0, ev_stable=1, ev_rose=0, ev_fell=0.
REQ-032 Reset asserted mid-command SHALL abort the command and discard all queued commands.

Structure
REQ-033 Package edge_seq_pkg SHALL hold the op enum (OP_HOLD, OP_RISE, OP_FALL, OP_TOGGLE), the state enum, and the default DEPTH/CNT_W constants.
REQ-034 The FIFO SHALL be a separate sub-module, edge_seq_fifo (DEPTH x (2+CNT_W), registered full/empty, async active-low reset).

Verification
REQ-035 INIT=0; push RISE len=0, FALL len=0, then 2 idle cycles -> sig_out 1 then 0; ev_rose then ev_fell; done 1 cycle each; ev_stable=1 on the following cycles.
REQ-036 Push TOGGLE len=3 then HOLD len=1 back-to-back -> sig_out toggles once and holds 6 cycles total; done on cycles 4 and 6; no gap cycle.
REQ-037 sig_out=1; push RISE len=1 -> sig_out stays 1; err rises at the op edge; err_clr pulse clears it; err_clr coinciding with a second illegal RISE -> err stays 1.
REQ-038 Hold cmd_valid high with 6 HOLD len=5 commands, DEPTH=4 -> cmd_ready drops after 4 entries (1 popped at the next edge, so 5 accepted before stall); no command lost; windows execute in order.
REQ-039 Assert rst_n low in cycle 2 of a len=4 command with 2 queued -> sig_out=INIT immediately; busy=0, cmd_ready=1 afterwards; no queued command executes.
REQ-040 Random op/len stream (1000 commands) against a reference model -> sig_out, done, and ev_* match every cycle; window lengths equal 1+cmd_len.

Source files
------------

// File: rtl/edge_seq_pkg.sv
// Shared types and defaults for the edge sequence generator.
package edge_seq_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned OP_W      = 2;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RISE   = 2'b01,
    OP_FALL   = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Level produced by an op; an illegal RISE/FALL leaves the level alone.
  function automatic logic apply_op(input op_e op, input logic cur);
    logic res;
    res = cur;
    case (op)
      OP_RISE:   res = 1'b1;
      OP_FALL:   res = 1'b0;
      OP_TOGGLE: res = ~cur;
      default:   res = cur;
    endcase
    return res;
  endfunction

  function automatic logic is_illegal(input op_e op, input logic cur);
    return ((op == OP_RISE) && cur) || ((op == OP_FALL) && !cur);
  endfunction

endpackage

// File: rtl/edge_seq_fifo.sv
// Command FIFO with registered full/empty flags; head is read combinationally.
module edge_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/edge_seq_gen.sv
// Queued edge/level command sequencer driving a single registered waveform.
module edge_seq_gen
  import edge_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter logic        INIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             sig_out,
  output logic             ev_rose,
  output logic             ev_fell,
  output logic             ev_stable,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int unsigned FW = OP_W + CNT_W;

  logic             push_c;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    head;
  op_e              head_op;
  logic [CNT_W-1:0] head_len;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] remain_nxt;
  logic             sig_nxt;
  logic             err_set_c;
  logic             prev;

  assign push_c   = cmd_valid && !fifo_full;
  assign head_op  = op_e'(head[FW-1 -: OP_W]);
  assign head_len = head[CNT_W-1:0];

  edge_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata ({cmd_op, cmd_len}),
    .pop   (pop_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      remain  <= '0;
      sig_out <= INIT;
      prev    <= INIT;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      remain  <= remain_nxt;
      sig_out <= sig_nxt;
      prev    <= sig_out;
      err     <= err_set_c || (err && !err_clr);
    end
  end

  // A window ends when remain hits zero; the next head is popped on that same edge.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    sig_nxt    = sig_out;
    pop_c      = 1'b0;
    err_set_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          sig_nxt    = apply_op(head_op, sig_out);
          err_set_c  = is_illegal(head_op, sig_out);
          remain_nxt = head_len;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (remain != '0) begin
          remain_nxt = remain - 1'b1;
        end else if (!fifo_empty) begin
          pop_c      = 1'b1;
          sig_nxt    = apply_op(head_op, sig_out);
          err_set_c  = is_illegal(head_op, sig_out);
          remain_nxt = head_len;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = !fifo_full;
    busy      = (state == ST_RUN) || !fifo_empty;
    done      = (state == ST_RUN) && (remain == '0);
    ev_rose   = sig_out && !prev;
    ev_fell   = !sig_out && prev;
    ev_stable = (sig_out == prev);
  end

endmodule

// File: tb/tb_edge_seq_gen.sv
// Directed and random checks of edge_seq_gen against a window-level model.
module tb_edge_seq_gen;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             sig_out;
  logic             ev_rose;
  logic             ev_fell;
  logic             ev_stable;
  logic             busy;
  logic             done;
  logic             err;
  logic             err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  edge_seq_gen #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .INIT  (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .sig_out   (sig_out),
    .ev_rose   (ev_rose),
    .ev_fell   (ev_fell),
    .ev_stable (ev_stable),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of accepted commands and the number of cycles left in the current window.
  typedef struct {
    logic [1:0] op;
    int         len;
  } mcmd_t;

  mcmd_t q[$];
  mcmd_t cur;
  int    left = 0;
  logic  m_sig = 1'b0;
  logic  m_prev = 1'b0;
  logic  m_err = 1'b0;
  logic  m_set;
  logic  m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      left   = 0;
      m_sig  = 1'b0;
      m_prev = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_set  = 1'b0;
      m_prev = m_sig;
      m_acc  = cmd_valid && (q.size() < DEPTH);
      if (left > 1) begin
        left--;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
        case (cur.op)
          2'b01: if (m_sig) m_set = 1'b1; else m_sig = 1'b1;
          2'b10: if (!m_sig) m_set = 1'b1; else m_sig = 1'b0;
          2'b11: m_sig = !m_sig;
          default: ;
        endcase
        left = 1 + cur.len;
      end else begin
        left = 0;
      end
      if (m_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (m_acc) q.push_back('{op: cmd_op, len: int'(cmd_len)});
    end
  end

  int done_cnt = 0;

  always @(negedge clk) begin
    chk("sig_out", 32'(sig_out), 32'(m_sig));
    chk("done", 32'(done), 32'(left == 1));
    chk("busy", 32'(busy), 32'((left > 0) || (q.size() > 0)));
    chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
    chk("ev_rose", 32'(ev_rose), 32'(m_sig && !m_prev));
    chk("ev_fell", 32'(ev_fell), 32'(!m_sig && m_prev));
    chk("ev_stable", 32'(ev_stable), 32'(m_sig == m_prev));
    chk("err", 32'(err), 32'(m_err));
    if (done) done_cnt++;
  end

  int n_acc = 0;
  int first_stall_acc = -1;

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send(input logic [1:0] op, input int len);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = CNT_W'(len);
    while (!cmd_ready && w < 300) begin
      if (first_stall_acc < 0) first_stall_acc = n_acc;
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("send_timeout", 32'(w), 32'(0));
    @(negedge clk);
    n_acc++;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    cmd_valid = 1'b0;
    while (busy && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("idle_timeout", 32'(w), 32'(0));
    @(negedge clk);
  endtask

  logic [5:0] done_v;
  logic [5:0] sig_v;
  int d0;
  int n;

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_stable", 32'(ev_stable), 32'(1));
    chk("rst_sig", 32'(sig_out), 32'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'(0));
    chk("post_rst_ready", 32'(cmd_ready), 32'(1));

    // RISE len0, FALL len0
    send(2'b01, 0);
    send(2'b10, 0);
    cmd_valid = 1'b0;
    chk("rf_sig1", 32'(sig_out), 32'(1));
    chk("rf_rose", 32'(ev_rose), 32'(1));
    chk("rf_done1", 32'(done), 32'(1));
    @(negedge clk);
    chk("rf_sig0", 32'(sig_out), 32'(0));
    chk("rf_fell", 32'(ev_fell), 32'(1));
    chk("rf_done2", 32'(done), 32'(1));
    @(negedge clk);
    chk("rf_stable", 32'(ev_stable), 32'(1));
    chk("rf_done_off", 32'(done), 32'(0));
    wait_idle();

    // TOGGLE len3 then HOLD len1 back-to-back
    send(2'b11, 3);
    send(2'b00, 1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      done_v[i] = done;
      sig_v[i]  = sig_out;
      @(negedge clk);
    end
    chk("th_done_pattern", 32'(done_v), 32'(6'b101000));
    chk("th_sig_pattern", 32'(sig_v), 32'(6'b111111));
    chk("th_idle_after", 32'(busy), 32'(0));
    wait_idle();

    // Illegal RISE with sig_out high, then err_clr and the set-wins case
    send(2'b01, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ill_err_set", 32'(err), 32'(1));
    chk("ill_sig_hold", 32'(sig_out), 32'(1));
    wait_idle();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ill_err_clr", 32'(err), 32'(0));
    send(2'b01, 0);
    cmd_valid = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ill_set_wins", 32'(err), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    wait_idle();

    // Six HOLD len5 with valid held high
    first_stall_acc = -1;
    n_acc = 0;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) send(2'b00, 5);
    cmd_valid = 1'b0;
    chk("full_first_stall", 32'(first_stall_acc), 32'(5));
    wait_idle();
    chk("full_windows", 32'(done_cnt - d0), 32'(6));

    // Reset mid-command with two queued
    send(2'b10, 0);
    wait_idle();
    send(2'b01, 4);
    send(2'b11, 2);
    send(2'b11, 2);
    cmd_valid = 1'b0;
    chk("mid_sig_pre", 32'(sig_out), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_sig_init", 32'(sig_out), 32'(0));
    chk("mid_busy", 32'(busy), 32'(0));
    chk("mid_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("mid_no_exec", 32'(done_cnt - d0), 32'(0));
    chk("mid_sig_idle", 32'(sig_out), 32'(0));

    // Maximum length must not wrap: 256-cycle window
    send(2'b00, 255);
    cmd_valid = 1'b0;
    @(negedge clk);
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("max_len_window", 32'(n), 32'(256));
    wait_idle();

    // Random stream
    for (int i = 0; i < 1000; i++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 31));
      if (r < 20)      len = r % 3;
      else if (r < 31) len = int'($urandom_range(0, 12));
      else             len = int'($urandom_range(200, 255));
      err_clr = ($urandom_range(0, 7) == 0);
      send(2'($urandom_range(0, 3)), len);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    err_clr = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
